// File: rtl/stream_deserializer_eof.sv
// stream_deserializer_eof
//   Packs Ratio consecutive narrow valid/ready beats into one wide word,
//   little-endian (first accepted beat in lane 0). A beat flagged in_eof
//   closes the word early; unfilled upper lanes are zero. Packet boundaries
//   therefore survive the width change and two packets never share a word.
//
// Parameters
//   DataBits : width of one input beat / one output lane
//   Ratio    : input beats per output word (>= 2)
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : narrow input handshake
//   in_data, in_eof       : narrow beat and its end-of-packet flag
//   out_valid/out_ready   : wide output handshake
//   out_data              : wide word, lane k = [k*DataBits +: DataBits]
//   out_eof               : word holds the packet's final beat
//   out_keep              : lane-valid mask (only with STREAM_DESERIALIZER_KEEP_EN)
//
// Build option
//   `define STREAM_DESERIALIZER_KEEP_EN adds the registered out_keep port.

module stream_deserializer_eof #(
  parameter int DataBits = 8,
  parameter int Ratio    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DataBits-1:0]       in_data,
  input  logic                      in_eof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Ratio*DataBits-1:0] out_data,
`ifdef STREAM_DESERIALIZER_KEEP_EN
  output logic [Ratio-1:0]          out_keep,
`endif
  output logic                      out_eof
);

  localparam int CntBits = (Ratio > 2) ? $clog2(Ratio) : 1;
  localparam logic [CntBits-1:0] LastLane = CntBits'(Ratio - 1);

  logic [CntBits-1:0]        cnt;
  logic [Ratio*DataBits-1:0] acc;
  logic [Ratio*DataBits-1:0] acc_next;
  logic [Ratio*DataBits-1:0] word_next;
  logic                      accept;
  logic                      closing;
`ifdef STREAM_DESERIALIZER_KEEP_EN
  logic [Ratio-1:0]          keep_next;
`endif

  // Depends only on registered state and the downstream ready.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign closing  = (cnt == LastLane) | in_eof;

  // word_next: lanes below cnt from the accumulator, lane cnt from the
  // incoming beat, lanes above cnt zero-padded.
  always_comb begin
    word_next = '0;
    acc_next  = acc;
`ifdef STREAM_DESERIALIZER_KEEP_EN
    keep_next = '0;
`endif
    for (int unsigned k = 0; k < Ratio; k++) begin
      if (32'(cnt) == k) begin
        word_next[k*DataBits +: DataBits] = in_data;
        acc_next[k*DataBits +: DataBits]  = in_data;
      end else if (32'(cnt) > k) begin
        word_next[k*DataBits +: DataBits] = acc[k*DataBits +: DataBits];
      end
`ifdef STREAM_DESERIALIZER_KEEP_EN
      keep_next[k] = (32'(cnt) >= k);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
      acc       <= '0;
`ifdef STREAM_DESERIALIZER_KEEP_EN
      out_keep  <= '0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A closing beat accepted in the same cycle as the downstream
      // handshake overrides the clear above and reloads back-to-back.
      if (accept) begin
        if (closing) begin
          out_valid <= 1'b1;
          out_data  <= word_next;
          out_eof   <= in_eof;
`ifdef STREAM_DESERIALIZER_KEEP_EN
          out_keep  <= keep_next;
`endif
          cnt       <= '0;
          acc       <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CntBits'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_deserializer_eof.sv
// Scoreboard bench for stream_deserializer_eof: one Ratio=2 and one Ratio=4
// instance. Stimulus pushes expected words into per-instance queues; monitors
// pop and compare whenever a word is handed off downstream.

module tb_stream_deserializer_eof;

  typedef struct {
    logic [31:0] data;
    logic        eof;
    logic [3:0]  keep;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Ratio=2 instance
  logic        i2_valid = 1'b0, i2_ready, i2_eof = 1'b0;
  logic [7:0]  i2_data = '0;
  logic        o2_valid, o2_ready = 1'b1, o2_eof;
  logic [15:0] o2_data;
  // Ratio=4 instance
  logic        i4_valid = 1'b0, i4_ready, i4_eof = 1'b0;
  logic [7:0]  i4_data = '0;
  logic        o4_valid, o4_ready = 1'b1, o4_eof;
  logic [31:0] o4_data;
`ifdef STREAM_DESERIALIZER_KEEP_EN
  logic [1:0]  o2_keep;
  logic [3:0]  o4_keep;
`endif

  int errors = 0;
  int checks = 0;

  exp_t q2[$];
  exp_t q4[$];
  logic [31:0] m2_acc = '0, m4_acc = '0;
  int m2_cnt = 0, m4_cnt = 0;

  logic rand_rdy = 1'b0;
  logic hold_low = 1'b0;

  stream_deserializer_eof #(.DataBits(8), .Ratio(2)) u2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (i2_valid),
    .in_ready  (i2_ready),
    .in_data   (i2_data),
    .in_eof    (i2_eof),
    .out_valid (o2_valid),
    .out_ready (o2_ready),
    .out_data  (o2_data),
`ifdef STREAM_DESERIALIZER_KEEP_EN
    .out_keep  (o2_keep),
`endif
    .out_eof   (o2_eof)
  );

  stream_deserializer_eof #(.DataBits(8), .Ratio(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (i4_valid),
    .in_ready  (i4_ready),
    .in_data   (i4_data),
    .in_eof    (i4_eof),
    .out_valid (o4_valid),
    .out_ready (o4_ready),
    .out_data  (o4_data),
`ifdef STREAM_DESERIALIZER_KEEP_EN
    .out_keep  (o4_keep),
`endif
    .out_eof   (o4_eof)
  );

  // out_ready of the Ratio=2 instance only changes just after a rising edge,
  // so it is stable whenever stimulus or monitors look at it.
  always @(posedge clk) begin
    #1;
    if (hold_low)      o2_ready = 1'b0;
    else if (rand_rdy) o2_ready = 1'($urandom_range(0, 1));
    else               o2_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push(input int which, input logic [7:0] d, input logic e);
    exp_t x;
    if (which == 2) begin
      m2_acc[m2_cnt*8 +: 8] = d;
      if (m2_cnt == 1 || e) begin
        x.data = m2_acc; x.eof = e; x.keep = 4'((1 << (m2_cnt + 1)) - 1);
        q2.push_back(x);
        m2_acc = '0; m2_cnt = 0;
      end else m2_cnt++;
    end else begin
      m4_acc[m4_cnt*8 +: 8] = d;
      if (m4_cnt == 3 || e) begin
        x.data = m4_acc; x.eof = e; x.keep = 4'((1 << (m4_cnt + 1)) - 1);
        q4.push_back(x);
        m4_acc = '0; m4_cnt = 0;
      end else m4_cnt++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int which, input logic [7:0] d, input logic e);
    int n = 0;
    if (which == 2) begin i2_valid = 1'b1; i2_data = d; i2_eof = e; end
    else            begin i4_valid = 1'b1; i4_data = d; i4_eof = e; end
    while (((which == 2) ? !i2_ready : !i4_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %h not accepted after %0d cycles, required acceptance", d, n);
    end else begin
      model_push(which, d, e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    i2_valid = 1'b0; i4_valid = 1'b0;
    i2_eof = 1'b0; i4_eof = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q2.size() != 0 || q4.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q2.size() + q4.size()), 32'd0);
  endtask

  // Ratio=2 monitor: hold-stability while stalled, then scoreboard pop.
  logic        h2_valid = 1'b0, h2_eof;
  logic [15:0] h2_data;
  exp_t        e2;
  always @(negedge clk) begin
    if (rst_n && h2_valid) begin
      chk("r2_hold_valid", 32'(o2_valid), 32'd1);
      chk("r2_hold_data", {16'd0, o2_data}, {16'd0, h2_data});
      chk("r2_hold_eof", 32'(o2_eof), 32'(h2_eof));
    end
    h2_valid = rst_n && o2_valid && !o2_ready;
    h2_data  = o2_data;
    h2_eof   = o2_eof;
    if (rst_n && o2_valid && o2_ready) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL r2_unexpected: got word %h with nothing expected", o2_data);
      end else begin
        e2 = q2.pop_front();
        chk("r2_data", {16'd0, o2_data}, e2.data);
        chk("r2_eof", 32'(o2_eof), 32'(e2.eof));
`ifdef STREAM_DESERIALIZER_KEEP_EN
        chk("r2_keep", 32'(o2_keep), 32'(e2.keep));
`endif
      end
    end
  end

  exp_t e4;
  always @(negedge clk) begin
    if (rst_n && o4_valid && o4_ready) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL r4_unexpected: got word %h with nothing expected", o4_data);
      end else begin
        e4 = q4.pop_front();
        chk("r4_data", o4_data, e4.data);
        chk("r4_eof", 32'(o4_eof), 32'(e4.eof));
`ifdef STREAM_DESERIALIZER_KEEP_EN
        chk("r4_keep", 32'(o4_keep), 32'(e4.keep));
`endif
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_valid2", 32'(o2_valid), 32'd0);
    chk("rst_data2", {16'd0, o2_data}, 32'd0);
    chk("rst_eof2", 32'(o2_eof), 32'd0);
    chk("rst_valid4", 32'(o4_valid), 32'd0);
    chk("rst_data4", o4_data, 32'd0);
`ifdef STREAM_DESERIALIZER_KEEP_EN
    chk("rst_keep2", 32'(o2_keep), 32'd0);
    chk("rst_keep4", 32'(o4_keep), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Ratio=2 basic packing, one-cycle latency
    send(2, 8'h11, 1'b0);
    send(2, 8'h22, 1'b0);
    chk("t1_w0_valid", 32'(o2_valid), 32'd1);
    chk("t1_w0_data", {16'd0, o2_data}, 32'h2211);
    send(2, 8'h33, 1'b0);
    send(2, 8'h44, 1'b1);
    chk("t1_w1_valid", 32'(o2_valid), 32'd1);
    chk("t1_w1_data", {16'd0, o2_data}, 32'h4433);
    chk("t1_w1_eof", 32'(o2_eof), 32'd1);
    idle();

    // Ratio=4 early EOF then full word
    send(4, 8'hA1, 1'b0);
    send(4, 8'hA2, 1'b1);
    chk("t2_w0_data", o4_data, 32'h0000A2A1);
    chk("t2_w0_eof", 32'(o4_eof), 32'd1);
    send(4, 8'hB1, 1'b0);
    send(4, 8'hB2, 1'b0);
    send(4, 8'hB3, 1'b0);
    send(4, 8'hB4, 1'b1);
    chk("t2_w1_data", o4_data, 32'hB4B3B2B1);
    chk("t2_w1_eof", 32'(o4_eof), 32'd1);
    idle();

    // Ratio=2 EOF on lane 0, then counter restarts at lane 0
    send(2, 8'h5A, 1'b1);
    chk("t3_w0_data", {16'd0, o2_data}, 32'h005A);
    chk("t3_w0_eof", 32'(o2_eof), 32'd1);
    send(2, 8'h01, 1'b0);
    send(2, 8'h02, 1'b0);
    chk("t3_w1_data", {16'd0, o2_data}, 32'h0201);
    chk("t3_w1_eof", 32'(o2_eof), 32'd0);
    idle();
    drain();

    // Backpressure: downstream stalls while the next beat waits
    hold_low = 1'b1;
    send(2, 8'h11, 1'b0);
    send(2, 8'h22, 1'b0);
    i2_valid = 1'b1; i2_data = 8'h33; i2_eof = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(i2_ready), 32'd0);
      chk("bp_out_data", {16'd0, o2_data}, 32'h2211);
      @(negedge clk);
    end
    hold_low = 1'b0;
    send(2, 8'h33, 1'b0);
    send(2, 8'h44, 1'b1);
    chk("bp_w1_data", {16'd0, o2_data}, 32'h4433);
    idle();
    drain();

    // Reset mid-word discards the partial lane
    send(2, 8'h77, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid_during", 32'(o2_valid), 32'd0);
    rst_n = 1'b1;
    m2_acc = '0; m2_cnt = 0;
    @(negedge clk);
    chk("rst_mid_valid_after", 32'(o2_valid), 32'd0);
    send(2, 8'h01, 1'b0);
    send(2, 8'h02, 1'b0);
    chk("rst_mid_first_word", {16'd0, o2_data}, 32'h0201);
    idle();
    drain();

    // Random gaps, random EOFs, random downstream ready
    rand_rdy = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send(2, 8'($urandom), 1'($urandom_range(0, 4) == 0));
    end
    idle();
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_deserializer_eof.md
Name: stream_deserializer_eof

Overview:
- Gathers Ratio consecutive narrow valid/ready input beats into one wide output beat.
- Little-endian packing: the first accepted beat lands in the LSB lane.
- An input EOF closes the current wide word early, so packet boundaries survive the width change.
- Sits on the receive side of narrow byte-stream links, opposite the EOF-aware serializer, and restores frame-aligned wide words.

Parameters:
- DataBits, 8, width of one input beat / one output lane.
- Ratio, 2, input beats per output word (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DataBits  input beat.
- in_eof  in  1  beat is the last of a packet.
- out_valid  out  1  wide word valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  Ratio*DataBits  wide word; lane k = bits [k*DataBits +: DataBits].
- out_eof  out  1  word contains the packet's final beat.
- out_keep  out  Ratio  lane-valid mask; present only with the optional feature.

Behaviour:
- Reset (rst_n low at a clk edge), values:
  - out_valid=0, out_eof=0, out_data=0.
  - Lane counter cnt=0, accumulator cleared.
  - out_keep=0 when present.
  - Reset mid-word discards all partial lanes; no partial output follows reset.
- in_ready = !out_valid | out_ready.
  - Registered state only; no dependence on in_valid, in_data or in_eof.
- On each accepted beat at lane index cnt (0..Ratio-1):
  - The beat is "closing" if cnt==Ratio-1 or in_eof==1.
  - Non-closing: write in_data into accumulator lane cnt; cnt<=cnt+1.
  - Closing, output register update (next edge):
    - out_data <= accumulator with lane cnt replaced by in_data; lanes above cnt forced to 0.
    - out_eof <= in_eof.
    - out_valid <= 1.
  - Closing, internal state: cnt <= 0 and accumulator cleared.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Throughput: one input beat per cycle sustained while out_ready=1; one wide word per Ratio cycles.
- Output handshake:
  - out_data, out_eof and out_keep hold stable while out_valid & !out_ready.
  - out_valid clears after acceptance unless a new closing beat is accepted in the same cycle, in which case the register reloads back-to-back.
- Backpressure: while out_valid & !out_ready, in_ready=0 and no beat is accepted, including non-closing ones. Accumulator and cnt are frozen.
- EOF cases:
  - EOF on lane 0 yields a word with only lane 0 meaningful and the rest zero.
  - EOF on lane Ratio-1 is a normal full word with out_eof=1.
  - Consecutive packets never share an output word.
- cnt width is clog2(Ratio), minimum 1. cnt never exceeds Ratio-1; wrap is via the closing rule only.
- in_valid=0 cycles leave cnt and the accumulator unchanged, so gaps mid-word are allowed.

Optional Feature:
- Macro: STREAM_DESERIALIZER_KEEP_EN.
- Defined:
  - The out_keep port exists.
  - Bit k=1 iff lane k was filled by an input beat: closing lane cnt gives keep = (1<<(cnt+1))-1.
  - out_keep is registered alongside out_data and reset to 0.
- Undefined:
  - No out_keep port and no keep logic.
  - Partial words are still zero-padded and flushed on EOF; consumers infer length from the packet protocol.

Test Plan:
- Ratio=2, DataBits=8: beats 0x11, 0x22(eof=0), 0x33, 0x44(eof=1), out_ready=1 -> out 0x2211 eof=0, then 0x4433 eof=1, each one cycle after its closing beat; keep=2'b11.
- Ratio=4: beats 0xA1, 0xA2(eof=1), then 0xB1..0xB4(last eof=1) -> 0x0000A2A1 eof=1 keep=4'b0011, then 0xB4B3B2B1 eof=1 keep=4'b1111.
- Ratio=2: single beat 0x5A eof=1 -> 0x005A eof=1 keep=2'b01; cnt back to 0, next beats 0x01, 0x02 -> 0x0201.
- Backpressure, Ratio=2: out_ready=0 for 5 cycles after word 0x2211 forms -> out_data holds 0x2211, in_ready=0, following beats 0x33, 0x44 stall. Release -> 0x4433 delivered with no loss or duplication.
- Random in_valid gaps and random out_ready over 1000 beats with random EOFs vs a reference packer model -> all words, eof and keep match in order.
- Reset: accept 0x77 (lane 0), pulse rst_n low one cycle, then beats 0x01, 0x02 -> no output containing 0x77; first word 0x0201; out_valid=0 during and right after reset.
